// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage that feeds the IF/ID pipeline register. It owns
//   the PC and issues one memory request at a time. A fetched instruction is
//   held until ID accepts it. A flush redirects the PC to a new target.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   flush, flush_pc redirect request (highest priority) and its target
//   allow_in_id     ID can accept the held instruction this cycle
//   valid_if        held instruction is presented to ID
//   ready_go_if     IF is done with the held instruction
//   pc_if           PC of the held or current fetch
//   instruction_if  held instruction
//   imem_req        memory request
//   imem_addr       request address (always equals pc_if)
//   imem_gnt        memory accepted the request this cycle
//   imem_rvalid     memory response valid (in order, at most one outstanding)
//   imem_rdata      memory response data
module if_fetch_stage #(
    parameter int unsigned   BUS_WIDTH  = 32,
    parameter int unsigned   DATA_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [BUS_WIDTH-1:0]  flush_pc,
    input  logic                  allow_in_id,
    output logic                  valid_if,
    output logic                  ready_go_if,
    output logic [BUS_WIDTH-1:0]  pc_if,
    output logic [DATA_WIDTH-1:0] instruction_if,
    output logic                  imem_req,
    output logic [BUS_WIDTH-1:0]  imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        REQ  = 4'b0010,
        WAIT = 4'b0100,
        HOLD = 4'b1000
    } state_t;

    state_t                state, state_n;
    logic [BUS_WIDTH-1:0]  pc, pc_n;
    logic [DATA_WIDTH-1:0] instr_buf, instr_buf_n;
    logic                  drop, drop_n;
    logic [BUS_WIDTH-1:0]  flush_target;

    // Redirect targets are always word aligned.
    assign flush_target = {flush_pc[BUS_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            instr_buf <= '0;
            drop      <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            instr_buf <= instr_buf_n;
            drop      <= drop_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        instr_buf_n = instr_buf;
        drop_n      = drop;
        valid_if    = 1'b0;
        ready_go_if = 1'b0;
        imem_req    = 1'b0;

        unique case (state)
            IDLE: begin
                state_n = REQ;
            end
            REQ: begin
                imem_req = !flush;
                if (flush) begin
                    pc_n = flush_target;
                end else if (imem_gnt) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    pc_n = flush_target;
                    if (imem_rvalid) begin
                        // The outstanding response arrives now, so there is
                        // nothing left to drop.
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        drop_n = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        instr_buf_n = imem_rdata;
                        state_n     = HOLD;
                    end
                end
            end
            HOLD: begin
                valid_if    = !flush;
                ready_go_if = 1'b1;
                if (flush) begin
                    pc_n    = flush_target;
                    state_n = REQ;
                end else if (allow_in_id) begin
                    pc_n    = pc + BUS_WIDTH'(4);
                    state_n = REQ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign pc_if          = pc;
    assign imem_addr      = pc;
    assign instruction_if = instr_buf;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. Inputs are driven at the falling edge,
//   and outputs are sampled 1 ns later. The DUT state changes on the rising
//   edge.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        allow_in_id;
    logic        valid_if;
    logic        ready_go_if;
    logic [31:0] pc_if;
    logic [31:0] instruction_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .BUS_WIDTH (32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .allow_in_id   (allow_in_id),
        .valid_if      (valid_if),
        .ready_go_if   (ready_go_if),
        .pc_if         (pc_if),
        .instruction_if(instruction_if),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for the falling edge of the next cycle.
    task automatic nxt();
        @(negedge clk);
    endtask

    // Settle after driving inputs, before outputs are sampled.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; flush_pc = '0; allow_in_id = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (3) nxt();
        settle();
        chk("rst_valid", {31'b0, valid_if}, 32'd0);
        chk("rst_ready_go", {31'b0, ready_go_if}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_pc", pc_if, 32'h0);
        chk("rst_instr", instruction_if, 32'h0);

        // 1: release reset. gnt is asserted immediately. A stray response in
        // IDLE is ignored.
        rst_n = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
        settle();
        chk("t1_idle_req", {31'b0, imem_req}, 32'd0);
        nxt(); imem_rvalid = 1'b0; settle();
        chk("t1_req_c2", {31'b0, imem_req}, 32'd1);
        chk("t1_addr_c2", imem_addr, 32'h0);
        chk("t1_idle_ignored", instruction_if, 32'h0);
        nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; settle();
        chk("t1_wait_req", {31'b0, imem_req}, 32'd0);
        nxt(); imem_rvalid = 1'b0; allow_in_id = 1'b1; settle();
        chk("t1_valid", {31'b0, valid_if}, 32'd1);
        chk("t1_ready_go", {31'b0, ready_go_if}, 32'd1);
        chk("t1_instr", instruction_if, 32'h13);
        chk("t1_pc", pc_if, 32'h0);
        nxt(); allow_in_id = 1'b0; settle();
        chk("t1_next_req", {31'b0, imem_req}, 32'd1);
        chk("t1_next_addr", imem_addr, 32'h4);

        // 2: backpressure for 5 cycles in HOLD.
        imem_gnt = 1'b1;
        nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001;
        nxt(); imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t2_stall_valid", {31'b0, valid_if}, 32'd1);
            chk("t2_stall_pc", pc_if, 32'h4);
            chk("t2_stall_instr", instruction_if, 32'hAAAA_0001);
            chk("t2_stall_req", {31'b0, imem_req}, 32'd0);
            nxt();
        end
        allow_in_id = 1'b1; settle();
        chk("t2_accept_valid", {31'b0, valid_if}, 32'd1);
        nxt(); allow_in_id = 1'b0; settle();
        chk("t2_next_req", {31'b0, imem_req}, 32'd1);
        chk("t2_next_addr", imem_addr, 32'h8);

        // 3: flush in WAIT; the late response must be dropped.
        imem_gnt = 1'b1;
        nxt(); imem_gnt = 1'b0; flush = 1'b1; flush_pc = 32'h100; settle();
        chk("t3_flush_req", {31'b0, imem_req}, 32'd0);
        nxt(); flush = 1'b0; settle();
        chk("t3_pc_redirect", pc_if, 32'h100);
        chk("t3_valid_a", {31'b0, valid_if}, 32'd0);
        nxt(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; settle();
        chk("t3_valid_b", {31'b0, valid_if}, 32'd0);
        nxt(); imem_rvalid = 1'b0; settle();
        chk("t3_valid_c", {31'b0, valid_if}, 32'd0);
        chk("t3_req", {31'b0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h100);
        chk("t3_instr_kept", instruction_if, 32'hAAAA_0001);

        // 4a: flush coinciding with rvalid in WAIT.
        imem_gnt = 1'b1;
        nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
        flush = 1'b1; flush_pc = 32'h203; settle();
        chk("t4a_valid", {31'b0, valid_if}, 32'd0);
        nxt(); flush = 1'b0; imem_rvalid = 1'b0; settle();
        chk("t4a_req", {31'b0, imem_req}, 32'd1);
        chk("t4a_addr", imem_addr, 32'h200);
        chk("t4a_instr_kept", instruction_if, 32'hAAAA_0001);

        // 4b: flush together with allow_in_id in HOLD.
        imem_gnt = 1'b1;
        nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
        nxt(); imem_rvalid = 1'b0; allow_in_id = 1'b1; flush = 1'b1; flush_pc = 32'h203; settle();
        chk("t4b_valid", {31'b0, valid_if}, 32'd0);
        chk("t4b_ready_go", {31'b0, ready_go_if}, 32'd1);
        chk("t4b_instr", instruction_if, 32'h00A0_0093);
        nxt(); flush = 1'b0; allow_in_id = 1'b0; settle();
        chk("t4b_req", {31'b0, imem_req}, 32'd1);
        chk("t4b_addr", imem_addr, 32'h200);

        // 5: gnt withheld for 4 cycles in REQ.
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t5_hold_req", {31'b0, imem_req}, 32'd1);
            chk("t5_hold_addr", imem_addr, 32'h200);
            nxt();
        end
        imem_gnt = 1'b1; settle();
        chk("t5_gnt_req", {31'b0, imem_req}, 32'd1);
        nxt(); imem_gnt = 1'b0; settle();
        chk("t5_wait_req", {31'b0, imem_req}, 32'd0);

        // 6: an unaligned flush target is aligned; then pc wraps on accept.
        flush = 1'b1; flush_pc = 32'hFFFF_FFFF;
        nxt(); flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        nxt(); imem_rvalid = 1'b0; settle();
        chk("t6_req", {31'b0, imem_req}, 32'd1);
        chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        nxt(); imem_rvalid = 1'b0; allow_in_id = 1'b1; settle();
        chk("t6_valid", {31'b0, valid_if}, 32'd1);
        chk("t6_pc", pc_if, 32'hFFFF_FFFC);
        chk("t6_instr", instruction_if, 32'h1234_5678);
        nxt(); allow_in_id = 1'b0; settle();
        chk("t6_wrap_addr", imem_addr, 32'h0);

        // 7: reset while a drop is pending clears it.
        imem_gnt = 1'b1;
        nxt(); imem_gnt = 1'b0; flush = 1'b1; flush_pc = 32'h40;
        nxt(); flush = 1'b0; rst_n = 1'b0;
        nxt(); rst_n = 1'b1; settle();
        chk("t7_rst_req", {31'b0, imem_req}, 32'd0);
        chk("t7_rst_pc", pc_if, 32'h0);
        chk("t7_rst_instr", instruction_if, 32'h0);
        nxt(); settle();
        chk("t7_req", {31'b0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0077;
        nxt(); imem_rvalid = 1'b0; settle();
        chk("t7_valid", {31'b0, valid_if}, 32'd1);
        chk("t7_instr", instruction_if, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
